// File: rtl/snake_engine.sv
// snake_engine: snake body held as a coordinate shift array. Each accepted
// step moves the head one cell (MOVE), then scans the body one segment per
// cycle for a self-collision (CHECK) and pulses done.
// Optional feature: define SNAKE_WRAP_EN to make the field edges wrap around
// instead of ending the game.
module snake_engine #(
  parameter int SIZE_X   = 10,
  parameter int SIZE_Y   = 10,
  parameter int COORD_W  = 8,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           step,
  input  logic                           grow,
  input  logic [1:0]                     key,
  output logic                           ready,
  output logic                           done,
  output logic                           game_over,
  output logic                           full,
  output logic [15:0]                    length,
  output logic [COORD_W-1:0]             head_x,
  output logic [COORD_W-1:0]             head_y,
  output logic [MAX_LEN*2*COORD_W-1:0]   snake_xy
);

  localparam int SEG_W = 2 * COORD_W;
  localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SIZE_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SIZE_Y - 1);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [1:0]                     state;
  logic [1:0]                     dir;
  logic                           grow_pend;
  logic [IDX_W-1:0]               idx;
  logic [MAX_LEN-1:0][SEG_W-1:0]  body;

  logic [COORD_W-1:0] hx, hy, nx, ny;
  logic               at_wall, oob, growing;

  assign hx        = body[0][SEG_W-1:COORD_W];
  assign hy        = body[0][COORD_W-1:0];
  assign head_x    = hx;
  assign head_y    = hy;
  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign full      = (length == 16'(MAX_LEN));
  assign oob       = at_wall & ~WRAP;
  assign growing   = grow_pend & ~full;

  // Slot 0 sits in the most significant bits of the flattened body.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign snake_xy[(MAX_LEN-g)*SEG_W-1 -: SEG_W] = body[g];
  end

  // Next head cell from dir; at_wall flags an edge crossing, nx/ny hold the wrapped cell.
  always_comb begin
    nx      = hx;
    ny      = hy;
    at_wall = 1'b0;
    case (dir)
      2'b00: if (hy == '0)    begin at_wall = 1'b1; ny = Y_MAX; end
             else                   ny = hy - COORD_W'(1);
      2'b01: if (hx == '0)    begin at_wall = 1'b1; nx = X_MAX; end
             else                   nx = hx - COORD_W'(1);
      2'b11: if (hy == Y_MAX) begin at_wall = 1'b1; ny = '0;    end
             else                   ny = hy + COORD_W'(1);
      2'b10: if (hx == X_MAX) begin at_wall = 1'b1; nx = '0;    end
             else                   nx = hx + COORD_W'(1);
      default: ;
    endcase
  end

  // Control FSM: step acceptance, direction, growth latch, length and collision scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dir       <= 2'b10;
      grow_pend <= 1'b0;
      game_over <= 1'b0;
      length    <= 16'd0;
      idx       <= '0;
    end else if (start) begin
      state     <= S_IDLE;
      dir       <= 2'b10;
      grow_pend <= 1'b0;
      game_over <= 1'b0;
      length    <= 16'(INIT_LEN);
      idx       <= '0;
    end else begin
      if (grow) grow_pend <= 1'b1;
      case (state)
        S_IDLE: if (step && length != 16'd0 && !game_over) begin
          // a direct reversal (w<->s, a<->d) keeps the old heading
          if ((key ^ dir) != 2'b11) dir <= key;
          state <= S_MOVE;
        end
        S_MOVE: begin
          // a grow pulse landing on this cycle is kept for the next move
          grow_pend <= grow;
          if (oob) begin
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            if (growing) length <= length + 16'd1;
            idx   <= IDX_W'(1);
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (body[idx] == body[0]) begin
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (idx == IDX_W'(length - 16'd1)) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Body storage: initial layout on start, shift-and-insert on a legal move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      body <= '0;
    end else if (start) begin
      for (int i = 0; i < MAX_LEN; i++)
        body[i] <= (i < INIT_LEN) ? {COORD_W'(SIZE_X/2 - i), COORD_W'(SIZE_Y/2)} : '0;
    end else if (state == S_MOVE && !oob) begin
      for (int i = MAX_LEN-1; i > 0; i--)
        body[i] <= body[i-1];
      body[0] <= {nx, ny};
      // without growth the shifted-out old tail must vanish
      for (int i = 1; i < MAX_LEN; i++)
        if (!growing && 16'(i) >= length) body[i] <= '0;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed plus random stepping of snake_engine against a
// queue-based model of the snake (push new head, drop tail unless growing).
module tb_snake_engine;
  localparam int SX = 10, SY = 10, CW = 8, ML = 32, IL = 4;
  localparam int VW = ML * 2 * CW;

  logic           clk = 1'b0, rst = 1'b0;
  logic           start = 1'b0, step = 1'b0, grow = 1'b0;
  logic [1:0]     key = 2'b10;
  logic           ready, done, game_over, full;
  logic [15:0]    length;
  logic [CW-1:0]  head_x, head_y;
  logic [VW-1:0]  snake_xy;

  snake_engine #(.SIZE_X(SX), .SIZE_Y(SY), .COORD_W(CW), .MAX_LEN(ML), .INIT_LEN(IL)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .grow(grow), .key(key),
    .ready(ready), .done(done), .game_over(game_over), .full(full), .length(length),
    .head_x(head_x), .head_y(head_y), .snake_xy(snake_xy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // model state
  int mx[$], my[$];
  int mdir = 2, mgp = 0, mgo = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_xy();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < ML; i++)
      if (i < mx.size()) v[(ML-i)*2*CW-1 -: 2*CW] = {CW'(mx[i]), CW'(my[i])};
    return v;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".len"},  VW'(length), VW'(mx.size()));
    chk({tag, ".xy"},   snake_xy, exp_xy());
    chk({tag, ".hx"},   VW'(head_x), VW'(mx.size() ? mx[0] : 0));
    chk({tag, ".hy"},   VW'(head_y), VW'(my.size() ? my[0] : 0));
    chk({tag, ".go"},   VW'(game_over), VW'(mgo));
    chk({tag, ".full"}, VW'(full), VW'(mx.size() == ML));
    chk({tag, ".rdy"},  VW'(ready), VW'(1));
    chk({tag, ".done"}, VW'(done), VW'(0));
  endtask

  task automatic model_start();
    mx.delete(); my.delete();
    for (int i = 0; i < IL; i++) begin mx.push_back(SX/2 - i); my.push_back(SY/2); end
    mdir = 2; mgp = 0; mgo = 0;
  endtask

  task automatic model_reset();
    mx.delete(); my.delete();
    mdir = 2; mgp = 0; mgo = 0;
  endtask

  // Applies one step to the model; returns accept flag and expected cycles
  // from the accept edge to the edge after which done is seen.
  task automatic model_step(input logic [1:0] kv, output int acc, output int lat);
    int dx, dy, nx, ny, wall, gnow;
    acc = (mx.size() != 0 && !mgo);
    lat = 0;
    if (!acc) return;
    if ((kv ^ 2'(mdir)) != 2'b11) mdir = kv;
    dx = 0; dy = 0;
    case (mdir)
      0: dy = -1;
      1: dx = -1;
      3: dy = 1;
      default: dx = 1;
    endcase
    nx = mx[0] + dx; ny = my[0] + dy;
    wall = (nx < 0 || nx >= SX || ny < 0 || ny >= SY);
`ifdef SNAKE_WRAP_EN
    nx = (nx + SX) % SX; ny = (ny + SY) % SY; wall = 0;
`endif
    if (wall) begin
      mgo = 1; mgp = 0; lat = 1;
      return;
    end
    gnow = mgp && mx.size() < ML;
    mgp = 0;
    mx.push_front(nx); my.push_front(ny);
    if (!gnow) begin void'(mx.pop_back()); void'(my.pop_back()); end
    lat = mx.size();
    for (int k = 1; k < mx.size(); k++)
      if (mx[k] == nx && my[k] == ny) begin mgo = 1; lat = k + 1; break; end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    model_start();
  endtask

  task automatic pulse_grow();
    @(negedge clk) grow = 1'b1;
    @(negedge clk) grow = 1'b0;
    mgp = 1;
  endtask

  task automatic do_step(input string tag, input logic [1:0] kv);
    int acc, lat, cyc, seen;
    model_step(kv, acc, lat);
    @(negedge clk) begin step = 1'b1; key = kv; end
    @(negedge clk) step = 1'b0;
    if (acc) begin
      chk({tag, ".busy"}, VW'(ready), VW'(0));
      cyc = 0;
      while (!done && cyc < 100) begin @(negedge clk); cyc++; end
      chk({tag, ".lat"}, VW'(cyc), VW'(lat));
      chk({tag, ".go@done"}, VW'(game_over), VW'(mgo));
      @(negedge clk);
    end else begin
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (done) seen++;
        @(negedge clk);
      end
      chk({tag, ".ignored"}, VW'(seen), VW'(0));
    end
    check_state(tag);
  endtask

  initial begin
    int n;
    // reset state
    #12;
    model_reset();
    check_state("reset");
    @(negedge clk) rst = 1'b1;
    do_step("len0", 2'b10);          // step with length 0 is ignored

    do_start();
    check_state("start");
    do_step("right", 2'b10);         // head (6,5)
    do_step("reverse", 2'b01);       // reversal ignored, head (7,5)
    pulse_grow();
    do_step("grow1", 2'b11);         // length 5
    pulse_grow(); pulse_grow();
    do_step("grow2", 2'b11);         // length 6 only
    do_step("r8", 2'b10);
    do_step("r9", 2'b10);
    do_step("wall", 2'b10);          // wall hit or wrap
    do_step("afterwall", 2'b11);

    // tight self-collision loop at length 5
    do_start();
    pulse_grow();
    do_step("loop.d", 2'b10);
    do_step("loop.s", 2'b11);
    do_step("loop.a", 2'b01);
    do_step("loop.w", 2'b00);
    chk("loop.hit", VW'(game_over), VW'(1));
    do_step("loop.ignored", 2'b11);
    do_start();
    check_state("loop.restart");

    // start while scanning aborts the step
    @(negedge clk) begin step = 1'b1; key = 2'b11; end
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin if (done) n++; @(negedge clk); end
    chk("abort.nodone", VW'(n), VW'(0));
    model_start();
    check_state("abort");

    // asynchronous reset mid-step
    @(negedge clk) begin step = 1'b1; key = 2'b11; end
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state("arst");
    @(negedge clk) rst = 1'b1;

    // random play
    do_start();
    for (int it = 0; it < 300; it++) begin
      if (mgo) begin
        if ($urandom_range(1, 0) == 1) do_step("rnd.dead", 2'($urandom_range(3, 0)));
        do_start();
      end else if ($urandom_range(49, 0) == 0) begin
        do_start();
      end
      if ($urandom_range(2, 0) == 0) pulse_grow();
      do_step("rnd", 2'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake body engine for the snake game. It holds the body as a coordinate shift array and advances the snake one cell per `step`. Each advance runs a multi-cycle self-collision scan and checks walls. Results are reported through a ready/done handshake. It sits between the key/timer logic and the field renderer, which reads `snake_xy` and `length`.

## Interface
- `SIZE_X`, 10, field width in cells (2..255)
- `SIZE_Y`, 10, field height in cells (2..255)
- `COORD_W`, 8, bits per coordinate
- `MAX_LEN`, 32, body storage depth in segments (≥ INIT_LEN, ≤ SIZE_X*SIZE_Y)
- `INIT_LEN`, 4, length after `start` (2..SIZE_X/2)
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: (re)initialise the snake; has priority over everything else
- `step` in 1: request one advance; sampled only while `ready`
- `grow` in 1: food eaten; single-cycle pulse, latched
- `key` in 2: direction; 00 w (y-1), 01 a (x-1), 11 s (y+1), 10 d (x+1)
- `ready` out 1: engine idle and able to accept `step`
- `done` out 1: one-cycle pulse at the end of each accepted step
- `game_over` out 1: sticky collision flag, cleared only by `start`/`rst`
- `full` out 1: `length == MAX_LEN`
- `length` out 16: current segment count
- `head_x`, `head_y` out COORD_W each: segment 0
- `snake_xy` out MAX_LEN*2*COORD_W: flattened body, segment i at MSB-first slot i as {x_i, y_i}; unused slots zero

## Operation
- States: IDLE, MOVE, CHECK, DONE.
- Reset values: `length`=0, all `snake_xy`=0, dir=10, grow_pend=0, `ready`=1, `done`=0, `game_over`=0, `full`=0, state IDLE.
- `start` (any state):
  - head = (SIZE_X/2, SIZE_Y/2); segment i = (SIZE_X/2 - i, SIZE_Y/2); remaining slots zero.
  - `length`=INIT_LEN, dir=10, grow_pend=0, `game_over`=0, state IDLE.
  - An in-flight step is aborted with no `done`.
- IDLE:
  - `step` is accepted only if `length`≠0 and !`game_over`; otherwise it is ignored.
  - On accept, `key` is captured. dir takes the new key unless key^dir==11 (reversal), in which case dir is kept. Go to MOVE.
- MOVE, 1 cycle:
  - Compute next head from dir.
  - Out of bounds without wrap: set `game_over`, leave the body unchanged, go to DONE.
  - Otherwise shift every segment i←i-1 and write the new head into slot 0.
  - If grow_pend and !`full`: `length`+1, and the new tail duplicates the old tail (slot `length`).
  - If not growing: slots ≥ `length` are cleared.
  - grow_pend is cleared in all cases. Go to CHECK with idx=1.
- CHECK, one segment per cycle:
  - Compare slot idx with the head. On match, set `game_over` and go to DONE.
  - Otherwise increment idx; after idx = `length`-1, go to DONE.
  - A head moving into the vacated old tail cell is legal, because the tail has already shifted.
- DONE: `done`=1 for one cycle, then IDLE.
- `grow` pulse in any state sets grow_pend; repeated pulses before a MOVE still grow by one only. A grow pulse in the same cycle as MOVE is applied at the next MOVE.
- Arithmetic uses COORD_W bits throughout. Bounds are 0..SIZE_X-1 and 0..SIZE_Y-1.

## Timing
- `step` sampled at edge E0 → `ready`=0 from E0.
- Body updates at E1; `snake_xy` and `length` are stable after E1.
- Collision scan covers edges E2..E(L), with L = new length.
- `done` is high for the cycle after E(L); `ready` returns at E(L+1).
- Total step latency is L+1 cycles. A wall hit gives `done` after E1 (latency 2).
- `game_over` is visible in the same cycle as `done`.

## Configuration
- `SNAKE_WRAP_EN` defined: walls wrap. x=SIZE_X-1 going d → 0; x=0 going a → SIZE_X-1; y likewise. Walls never cause `game_over`.
- Undefined: leaving the field sets `game_over` and the body freezes (the wall-hit rule under Operation).

## Test plan
- `rst` low, then `start`, with defaults → `length`=4, head (5,5), segments (4,5),(3,5),(2,5); `ready`=1.
- `step` with key=10 → `done` 5 cycles after accept; head (6,5), tail (3,5); key=01 (reversal) on the next step is ignored and head goes to (7,5).
- `grow` pulse, then `step` → `length`=5, old tail cell retained; two `grow` pulses before one step → `length` +1 only.
- Drive the head to x=9 with key=10, then `step` → without the macro, `game_over`=1, `done` 2 cycles after accept, body unchanged; with `SNAKE_WRAP_EN`, head x=0 and `game_over`=0.
- Length 5, key sequence s,a,w (tight loop) → `game_over`=1 on the step whose head hits its own body; further `step` ignored; `start` clears `game_over`.
- `start` asserted during CHECK → no `done`, state IDLE, initial body restored; `rst` low mid-step → all outputs return to reset values asynchronously.
